// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer: circular entry storage plus an in-order drain onto the data bus.
// Bus errors report the faulting PC and discard everything still queued.
module mor1kx_store_buffer_drain #(
    parameter int DEPTH_WIDTH          = 8,
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            write_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dat_i,
    input  logic [3:0]                      bsel_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
    input  logic                            atomic_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [DEPTH_WIDTH:0]            count_o,
    input  logic                            flush_i,
    output logic                            dbus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
    output logic [3:0]                      dbus_bsel_o,
    output logic                            dbus_we_o,
    output logic                            dbus_atomic_o,
    input  logic                            dbus_ack_i,
    input  logic                            dbus_err_i,
    output logic                            err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] err_pc_o
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int EW = 3*OW + 5;

    typedef enum logic [1:0] {IDLE, READ, REQ} state_t;

    state_t               state, state_nxt;
    logic [DEPTH_WIDTH:0] wptr, rptr, flush_ptr;
    logic                 flush_pending;
    logic [EW-1:0]        mem [0:(1<<DEPTH_WIDTH)-1];
    logic [EW-1:0]        rdata;
    logic [OW-1:0]        cur_pc;
    logic                 push, re, latch, done_ok, done_err, flush_now;

    assign empty_o   = (wptr == rptr);
    assign full_o    = (wptr[DEPTH_WIDTH] != rptr[DEPTH_WIDTH]) &&
                       (wptr[DEPTH_WIDTH-1:0] == rptr[DEPTH_WIDTH-1:0]);
    assign count_o   = wptr - rptr;
    assign push      = write_i && !full_o;
    assign dbus_we_o = dbus_req_o;

    // Registered read, no bypass: IDLE only reads slots that are already written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[DEPTH_WIDTH-1:0]] <= {adr_i, dat_i, bsel_i, pc_i, atomic_i};
        if (re)
            rdata <= mem[rptr[DEPTH_WIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        re        = 1'b0;
        latch     = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        flush_now = 1'b0;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    flush_now = 1'b1;
                end else if (!empty_o) begin
                    re        = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = flush_i ? IDLE : REQ;
                flush_now = flush_i;
                latch     = !flush_i;
            end
            REQ: begin
                if (dbus_err_i) begin
                    done_err  = 1'b1;
                    state_nxt = IDLE;
                end else if (dbus_ack_i) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flush targets use the pre-increment wptr so a same-cycle push survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            flush_ptr     <= '0;
            flush_pending <= 1'b0;
            dbus_req_o    <= 1'b0;
            dbus_adr_o    <= '0;
            dbus_dat_o    <= '0;
            dbus_bsel_o   <= '0;
            dbus_atomic_o <= 1'b0;
            cur_pc        <= '0;
            err_o         <= 1'b0;
            err_pc_o      <= '0;
        end else begin
            err_o <= 1'b0;
            if (push)
                wptr <= wptr + 1'b1;
            if (flush_now)
                rptr <= wptr;
            if (latch) begin
                dbus_req_o    <= 1'b1;
                dbus_adr_o    <= rdata[EW-1 -: OW];
                dbus_dat_o    <= rdata[EW-OW-1 -: OW];
                dbus_bsel_o   <= rdata[OW+4:OW+1];
                cur_pc        <= rdata[OW:1];
                dbus_atomic_o <= rdata[0];
            end
            if (state == REQ && flush_i) begin
                flush_pending <= 1'b1;
                flush_ptr     <= wptr;
            end
            if (done_err) begin
                dbus_req_o    <= 1'b0;
                err_o         <= 1'b1;
                err_pc_o      <= cur_pc;
                rptr          <= wptr;
                flush_pending <= 1'b0;
            end else if (done_ok) begin
                dbus_req_o    <= 1'b0;
                flush_pending <= 1'b0;
                if (flush_i)            rptr <= wptr;
                else if (flush_pending) rptr <= flush_ptr;
                else                    rptr <= rptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Randomized bench: an issue-order queue model predicts every bus write.
module tb_mor1kx_store_buffer_drain;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] adr_i = '0, dat_i = '0, pc_i = '0;
    logic [3:0]  bsel_i = '0;
    logic        atomic_i = 1'b0;
    logic        full_o, empty_o;
    logic [8:0]  count_o;
    logic        flush_i = 1'b0;
    logic        dbus_req_o, dbus_we_o, dbus_atomic_o;
    logic [31:0] dbus_adr_o, dbus_dat_o;
    logic [3:0]  dbus_bsel_o;
    logic        dbus_ack_i = 1'b0, dbus_err_i = 1'b0;
    logic        err_o;
    logic [31:0] err_pc_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [100:0] q[$];

    mor1kx_store_buffer_drain #(.DEPTH_WIDTH(8), .OPTION_OPERAND_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .write_i(write_i), .adr_i(adr_i), .dat_i(dat_i),
        .bsel_i(bsel_i), .pc_i(pc_i), .atomic_i(atomic_i), .full_o(full_o),
        .empty_o(empty_o), .count_o(count_o), .flush_i(flush_i),
        .dbus_req_o(dbus_req_o), .dbus_adr_o(dbus_adr_o), .dbus_dat_o(dbus_dat_o),
        .dbus_bsel_o(dbus_bsel_o), .dbus_we_o(dbus_we_o), .dbus_atomic_o(dbus_atomic_o),
        .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .err_o(err_o), .err_pc_o(err_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [100:0] gen();
        return {$urandom(), $urandom(), 4'($urandom()), $urandom(), 1'($urandom())};
    endfunction

    // Push one entry; the model only accepts it if the buffer is not full.
    task automatic push(input logic [100:0] e);
        write_i = 1'b1;
        {adr_i, dat_i, bsel_i, pc_i, atomic_i} = e;
        if (!full_o) q.push_back(e);
        @(negedge clk);
        write_i = 1'b0;
    endtask

    // Wait for a request, compare it to the model head, hold for dly cycles, then complete.
    task automatic serve(input int dly, input bit use_err);
        logic [100:0] e;
        int n = 0;
        while (!dbus_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(dbus_req_o), 1);
        if (q.size() == 0) begin
            chk("unexpected_req", 32'(dbus_req_o), 0);
            e = '0;
        end else begin
            e = q.pop_front();
        end
        chk("adr", dbus_adr_o, e[100:69]);
        chk("dat", dbus_dat_o, e[68:37]);
        chk("bsel", 32'(dbus_bsel_o), 32'(e[36:33]));
        chk("atomic", 32'(dbus_atomic_o), 32'(e[0]));
        chk("we", 32'(dbus_we_o), 1);
        repeat (dly) begin
            @(negedge clk);
            chk("hold_req", 32'(dbus_req_o), 1);
            chk("hold_adr", dbus_adr_o, e[100:69]);
        end
        if (use_err) dbus_err_i = 1'b1;
        else         dbus_ack_i = 1'b1;
        @(negedge clk);
        dbus_ack_i = 1'b0;
        dbus_err_i = 1'b0;
        chk("req_drop", 32'(dbus_req_o), 0);
    endtask

    task automatic no_req(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen = seen | dbus_req_o;
        end
        chk(tag, 32'(seen), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [100:0] e, x;
        int n;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dbus_req_o), 0);
        chk("rst_empty", 32'(empty_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_errpc", err_pc_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single push: request visible two edges after the push edge
        e = {32'h100, 32'hDEADBEEF, 4'hF, 32'h2000, 1'b0};
        push(e);
        chk("lat_n0", 32'(dbus_req_o), 0);
        @(negedge clk);
        chk("lat_n1", 32'(dbus_req_o), 0);
        @(negedge clk);
        chk("lat_n2", 32'(dbus_req_o), 1);
        serve(0, 0);
        chk("single_empty", 32'(empty_o), 1);
        chk("single_count", 32'(count_o), 0);

        // fill to capacity with the bus stalled
        for (int i = 0; i < 256; i++) push(gen());
        chk("fill_full", 32'(full_o), 1);
        chk("fill_count", 32'(count_o), 256);
        push(gen());
        chk("overflow_count", 32'(count_o), 256);
        // push while full coinciding with an ack pop is still dropped
        chk("full_head_adr", dbus_adr_o, q[0][100:69]);
        write_i = 1'b1;
        {adr_i, dat_i, bsel_i, pc_i, atomic_i} = gen();
        dbus_ack_i = 1'b1;
        @(negedge clk);
        write_i = 1'b0;
        dbus_ack_i = 1'b0;
        void'(q.pop_front());
        chk("full_ack_count", 32'(count_o), 255);
        chk("full_ack_notfull", 32'(full_o), 0);
        for (int i = 0; i < 255; i++) serve($urandom_range(0, 2), 0);
        chk("drain_empty", 32'(empty_o), 1);

        // continuous push and drain across the index wrap
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    push(gen());
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 300; j++) serve($urandom_range(0, 5), 0);
            end
        join
        chk("stream_model_empty", 32'(q.size()), 0);
        chk("stream_empty", 32'(empty_o), 1);

        // bus error on the first of three
        for (int i = 0; i < 3; i++) begin
            e = gen();
            e[32:1] = 32'h3004 + 32'(4 * i);
            push(e);
        end
        serve(0, 1);
        q.delete();
        chk("err_pulse", 32'(err_o), 1);
        chk("err_pc", err_pc_o, 32'h3004);
        chk("err_empty", 32'(empty_o), 1);
        chk("err_count", 32'(count_o), 0);
        @(negedge clk);
        chk("err_pulse_end", 32'(err_o), 0);
        no_req("err_no_req", 8);
        chk("err_pc_hold", err_pc_o, 32'h3004);

        // flush in IDLE (k=0) and in READ (k=1): nothing issued
        for (int k = 0; k < 2; k++) begin
            push(gen());
            repeat (k) @(negedge clk);
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
            q.delete();
            no_req("flush_early_no_req", 6);
            chk("flush_early_empty", 32'(empty_o), 1);
        end

        // flush during REQ with 4 queued plus a same-cycle push
        for (int i = 0; i < 4; i++) push(gen());
        n = 0;
        while (!dbus_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_req_up", 32'(dbus_req_o), 1);
        e = q[0];
        x = gen();
        flush_i = 1'b1;
        write_i = 1'b1;
        {adr_i, dat_i, bsel_i, pc_i, atomic_i} = x;
        @(negedge clk);
        flush_i = 1'b0;
        write_i = 1'b0;
        q.delete();
        q.push_back(e);
        q.push_back(x);
        serve(2, 0);
        serve(0, 0);
        no_req("flush_no_req", 8);
        chk("flush_empty", 32'(empty_o), 1);

        // asynchronous reset in the middle of a request
        push(gen());
        push(gen());
        n = 0;
        while (!dbus_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_req_up", 32'(dbus_req_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(dbus_req_o), 0);
        chk("arst_count", 32'(count_o), 0);
        chk("arst_empty", 32'(empty_o), 1);
        chk("arst_errpc", err_pc_o, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(gen());
        serve(1, 0);
        chk("arst_after_empty", 32'(empty_o), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
